// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath top that consumes its selects.
package ctrl_pkg;

    typedef enum logic [4:0] {
        RST_SP, FETCH, MEM_WAIT, IR_LOAD, DECODE,
        R_EXEC, R_WB, I_EXEC, I_WB,
        ADDR, SW_MEM, LW_MEM, LW_WAIT, LW_MDR, LW_WB,
        BR, JMP, EXC_EPC, EXC_VEC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ULA_PASS = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;
    localparam logic [2:0] ULA_CMP  = 3'b111;

    localparam logic [1:0] MEM_PC     = 2'd0;
    localparam logic [1:0] MEM_ALUOUT = 2'd1;

    localparam logic [1:0] WR_RT = 2'd0;
    localparam logic [1:0] WR_RD = 2'd1;
    localparam logic [1:0] WR_SP = 2'd3;

    localparam logic [2:0] WD_ALUOUT  = 3'd0;
    localparam logic [2:0] WD_MDR     = 3'd1;
    localparam logic [2:0] WD_SP_INIT = 3'd2;

    localparam logic       ULA_A_PC  = 1'b0;
    localparam logic       ULA_A_REG = 1'b1;

    localparam logic [1:0] ULA_B_REG    = 2'd0;
    localparam logic [1:0] ULA_B_FOUR   = 2'd1;
    localparam logic [1:0] ULA_B_SEXT   = 2'd2;
    localparam logic [1:0] ULA_B_BRANCH = 2'd3;

    localparam logic [1:0] PC_ULA    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_EXC    = 2'd3;

    localparam logic EXC_INVALID  = 1'b0;
    localparam logic EXC_OVERFLOW = 1'b1;

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       rb_w;
        logic       ab_w;
        logic       alu_out_w;
        logic       mdr_w;
        logic       epc_w;
        logic [2:0] ula_c;
        logic [1:0] m_mem;
        logic [1:0] m_writereg;
        logic [2:0] m_wdata;
        logic       m_ula_a;
        logic [1:0] m_ula_b;
        logic [1:0] m_pc;
    } ctrl_out_t;

    function automatic logic funct_valid(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
    endfunction

endpackage

// File: rtl/ctrl_if.sv
// Control bundle between ctrl_unit (master) and the datapath (slave): IR fields and ULA flags in, enables and selects out.
interface ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       of;
    logic       eq;
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       rb_w;
    logic       ab_w;
    logic       alu_out_w;
    logic       mdr_w;
    logic       epc_w;
    logic [2:0] ula_c;
    logic [1:0] m_mem;
    logic [1:0] m_writereg;
    logic [2:0] m_wdata;
    logic       m_ula_a;
    logic [1:0] m_ula_b;
    logic [1:0] m_pc;
    logic       exc_cause;

    modport master (
        input  opcode, funct, of, eq,
        output pc_w, mem_w, ir_w, rb_w, ab_w, alu_out_w, mdr_w, epc_w,
               ula_c, m_mem, m_writereg, m_wdata, m_ula_a, m_ula_b, m_pc, exc_cause
    );

    modport slave (
        output opcode, funct, of, eq,
        input  pc_w, mem_w, ir_w, rb_w, ab_w, alu_out_w, mdr_w, epc_w,
               ula_c, m_mem, m_writereg, m_wdata, m_ula_a, m_ula_b, m_pc, exc_cause
    );
endinterface

// File: rtl/ctrl_out_dec.sv
// Purpose: maps FSM state (plus funct in R_EXEC) to the datapath control bundle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the branch pc_w qualification is applied by the parent.
module ctrl_out_dec
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] funct,
    output ctrl_out_t  out
);

    always_comb begin
        out = '0;
        case (state)
            RST_SP: begin
                out.rb_w       = 1'b1;
                out.m_writereg = WR_SP;
                out.m_wdata    = WD_SP_INIT;
            end
            FETCH: begin
                out.m_mem   = MEM_PC;
                out.m_ula_a = ULA_A_PC;
                out.m_ula_b = ULA_B_FOUR;
                out.ula_c   = ULA_ADD;
                out.pc_w    = 1'b1;
                out.m_pc    = PC_ULA;
            end
            IR_LOAD: out.ir_w = 1'b1;
            DECODE: begin
                out.ab_w      = 1'b1;
                out.m_ula_a   = ULA_A_PC;
                out.m_ula_b   = ULA_B_BRANCH;
                out.ula_c     = ULA_ADD;
                out.alu_out_w = 1'b1;
            end
            R_EXEC: begin
                out.m_ula_a   = ULA_A_REG;
                out.m_ula_b   = ULA_B_REG;
                out.alu_out_w = 1'b1;
                case (funct)
                    FN_ADD:  out.ula_c = ULA_ADD;
                    FN_SUB:  out.ula_c = ULA_SUB;
                    FN_AND:  out.ula_c = ULA_AND;
                    default: out.ula_c = ULA_PASS;
                endcase
            end
            I_EXEC, ADDR: begin
                out.m_ula_a   = ULA_A_REG;
                out.m_ula_b   = ULA_B_SEXT;
                out.ula_c     = ULA_ADD;
                out.alu_out_w = 1'b1;
            end
            R_WB: begin
                out.rb_w       = 1'b1;
                out.m_writereg = WR_RD;
                out.m_wdata    = WD_ALUOUT;
            end
            I_WB: begin
                out.rb_w       = 1'b1;
                out.m_writereg = WR_RT;
                out.m_wdata    = WD_ALUOUT;
            end
            SW_MEM: begin
                out.m_mem = MEM_ALUOUT;
                out.mem_w = 1'b1;
            end
            LW_MEM: out.m_mem = MEM_ALUOUT;
            LW_MDR: out.mdr_w = 1'b1;
            LW_WB: begin
                out.rb_w       = 1'b1;
                out.m_writereg = WR_RT;
                out.m_wdata    = WD_MDR;
            end
            BR: begin
                out.m_ula_a = ULA_A_REG;
                out.m_ula_b = ULA_B_REG;
                out.ula_c   = ULA_CMP;
                out.m_pc    = PC_ALUOUT;
            end
            JMP: begin
                out.pc_w = 1'b1;
                out.m_pc = PC_JUMP;
            end
`ifdef CTRL_EXC_EN
            EXC_EPC: begin
                out.m_ula_a = ULA_A_PC;
                out.m_ula_b = ULA_B_FOUR;
                out.ula_c   = ULA_SUB;
                out.epc_w   = 1'b1;
            end
            EXC_VEC: begin
                out.pc_w = 1'b1;
                out.m_pc = PC_EXC;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Purpose: multicycle Moore control FSM for the MIPS-subset datapath; CTRL_EXC_EN builds the EPC/vector exception path.
// Latency: outputs decode the registered state; only BR pc_w also looks at eq in the same cycle.
// Backpressure: none; fixed cycle counts per instruction class, memory latency is a fixed wait state.
module ctrl_unit
    import ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    ctrl_if.master bus
);

    state_t    state;
    state_t    state_eff;
    ctrl_out_t dec_out;
    logic      br_take;

    // Reset shows RST_SP outputs immediately, not only after the first edge.
    assign state_eff = reset ? RST_SP : state;

    ctrl_out_dec u_dec (
        .state (state_eff),
        .funct (bus.funct),
        .out   (dec_out)
    );

    assign br_take = (bus.opcode == OP_BEQ) ? bus.eq : !bus.eq;

    assign bus.pc_w       = (state_eff == BR) ? br_take : dec_out.pc_w;
    assign bus.mem_w      = dec_out.mem_w;
    assign bus.ir_w       = dec_out.ir_w;
    assign bus.rb_w       = dec_out.rb_w;
    assign bus.ab_w       = dec_out.ab_w;
    assign bus.alu_out_w  = dec_out.alu_out_w;
    assign bus.mdr_w      = dec_out.mdr_w;
    assign bus.epc_w      = dec_out.epc_w;
    assign bus.ula_c      = dec_out.ula_c;
    assign bus.m_mem      = dec_out.m_mem;
    assign bus.m_writereg = dec_out.m_writereg;
    assign bus.m_wdata    = dec_out.m_wdata;
    assign bus.m_ula_a    = dec_out.m_ula_a;
    assign bus.m_ula_b    = dec_out.m_ula_b;
    assign bus.m_pc       = dec_out.m_pc;

`ifdef CTRL_EXC_EN
    logic exc_cause_q;
    assign bus.exc_cause = exc_cause_q & ~reset;
`else
    logic unused_of;
    assign unused_of     = bus.of;
    assign bus.exc_cause = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_SP;
`ifdef CTRL_EXC_EN
            exc_cause_q <= 1'b0;
`endif
        end else begin
            case (state)
                RST_SP:   state <= FETCH;
                FETCH:    state <= MEM_WAIT;
                MEM_WAIT: state <= IR_LOAD;
                IR_LOAD:  state <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:     state <= R_EXEC;
                        OP_ADDI:      state <= I_EXEC;
                        OP_LW, OP_SW: state <= ADDR;
                        OP_BEQ, OP_BNE: state <= BR;
                        OP_J:         state <= JMP;
                        default: begin
`ifdef CTRL_EXC_EN
                            state       <= EXC_EPC;
                            exc_cause_q <= EXC_INVALID;
`else
                            state       <= FETCH;
`endif
                        end
                    endcase
                end
                R_EXEC: begin
                    if (!funct_valid(bus.funct)) begin
`ifdef CTRL_EXC_EN
                        state       <= EXC_EPC;
                        exc_cause_q <= EXC_INVALID;
`else
                        state       <= FETCH;
`endif
                    end
`ifdef CTRL_EXC_EN
                    else if (bus.of) begin
                        state       <= EXC_EPC;
                        exc_cause_q <= EXC_OVERFLOW;
                    end
`endif
                    else begin
                        state <= R_WB;
                    end
                end
                I_EXEC: begin
`ifdef CTRL_EXC_EN
                    if (bus.of) begin
                        state       <= EXC_EPC;
                        exc_cause_q <= EXC_OVERFLOW;
                    end else begin
                        state <= I_WB;
                    end
`else
                    state <= I_WB;
`endif
                end
                ADDR:    state <= (bus.opcode == OP_LW) ? LW_MEM : SW_MEM;
                LW_MEM:  state <= LW_WAIT;
                LW_WAIT: state <= LW_MDR;
                LW_MDR:  state <= LW_WB;
`ifdef CTRL_EXC_EN
                EXC_EPC: state <= EXC_VEC;
`endif
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: per-instruction cycle plans from a reference model, compared by an independent monitor.
module tb_ctrl_unit;

`ifdef CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       rb_w;
        logic       ab_w;
        logic       alu_out_w;
        logic       mdr_w;
        logic       epc_w;
        logic [2:0] ula_c;
        logic [1:0] m_mem;
        logic [1:0] m_writereg;
        logic [2:0] m_wdata;
        logic       m_ula_a;
        logic [1:0] m_ula_b;
        logic [1:0] m_pc;
        logic       exc_cause;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    ctrl_if bus ();

    ctrl_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t plan[$];
    logic m_cause   = 1'b0;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    bit   stim_done = 1'b0;
    int   drain     = 0;

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.exc_cause = m_cause;
        return e;
    endfunction

    function automatic exp_t alu_step(input logic a, input logic [1:0] b, input logic [2:0] op);
        exp_t e;
        e = blank();
        e.m_ula_a = a;
        e.m_ula_b = b;
        e.ula_c = op;
        e.alu_out_w = 1'b1;
        return e;
    endfunction

    function automatic exp_t wb_step(input logic [1:0] dst, input logic [2:0] src);
        exp_t e;
        e = blank();
        e.rb_w = 1'b1;
        e.m_writereg = dst;
        e.m_wdata = src;
        return e;
    endfunction

    // Trap: save PC-4 into EPC, then load the exception vector.
    task automatic add_exc(input logic cause);
        exp_t e;
        if (EXC_EN) begin
            m_cause = cause;
            e = blank(); e.ula_c = 3'b010; e.m_ula_b = 2'd1; e.epc_w = 1'b1;
            plan.push_back(e);
            e = blank(); e.pc_w = 1'b1; e.m_pc = 2'd3;
            plan.push_back(e);
        end
    endtask

    task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic ofv, input logic eqv);
        exp_t e;
        bit   fn_ok;
        plan.delete();
        e = blank(); e.m_ula_b = 2'd1; e.ula_c = 3'b001; e.pc_w = 1'b1;
        plan.push_back(e);
        plan.push_back(blank());
        e = blank(); e.ir_w = 1'b1;
        plan.push_back(e);
        e = alu_step(1'b0, 2'd3, 3'b001); e.ab_w = 1'b1;
        plan.push_back(e);
        case (op)
            6'h00: begin
                fn_ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24);
                plan.push_back(alu_step(1'b1, 2'd0,
                    (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000));
                if (!fn_ok) add_exc(1'b0);
                else if (ofv && EXC_EN) add_exc(1'b1);
                else plan.push_back(wb_step(2'd1, 3'd0));
            end
            6'h08: begin
                plan.push_back(alu_step(1'b1, 2'd2, 3'b001));
                if (ofv && EXC_EN) add_exc(1'b1);
                else plan.push_back(wb_step(2'd0, 3'd0));
            end
            6'h23, 6'h2B: begin
                plan.push_back(alu_step(1'b1, 2'd2, 3'b001));
                e = blank(); e.m_mem = 2'd1; e.mem_w = (op == 6'h2B);
                plan.push_back(e);
                if (op == 6'h23) begin
                    plan.push_back(blank());
                    e = blank(); e.mdr_w = 1'b1;
                    plan.push_back(e);
                    plan.push_back(wb_step(2'd0, 3'd1));
                end
            end
            6'h04, 6'h05: begin
                e = blank(); e.m_ula_a = 1'b1; e.ula_c = 3'b111; e.m_pc = 2'd1;
                e.pc_w = (op == 6'h04) ? eqv : !eqv;
                plan.push_back(e);
            end
            6'h02: begin
                e = blank(); e.pc_w = 1'b1; e.m_pc = 2'd2;
                plan.push_back(e);
            end
            default: add_exc(1'b0);
        endcase
    endtask

    // Drives the first 'cut' cycles of the planned instruction; of/eq are only meaningful in cycle 5.
    task automatic run_plan(input logic [5:0] op, input logic [5:0] fn, input logic ofv, input logic eqv, input int cut);
        for (int k = 0; k < plan.size() && k < cut; k++) begin
            bus.opcode = (k < 3) ? 6'($urandom) : op;
            bus.funct  = (k < 3) ? 6'($urandom) : fn;
            bus.of     = (k == 4) ? ofv : 1'($urandom);
            bus.eq     = (k == 4) ? eqv : 1'($urandom);
            sb.push_back(plan[k]);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic ofv, input logic eqv);
        plan_instr(op, fn, ofv, eqv);
        run_plan(op, fn, ofv, eqv, plan.size());
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        m_cause = 1'b0;
        e = wb_step(2'd3, 3'd2);
        for (int i = 0; i <= n; i++) begin
            reset      = (i < n);
            bus.opcode = 6'($urandom);
            bus.funct  = 6'($urandom);
            bus.of     = 1'($urandom);
            bus.eq     = 1'($urandom);
            sb.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t exp_v;
        exp_t got_v;
        cyc++;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            got_v = {bus.pc_w, bus.mem_w, bus.ir_w, bus.rb_w, bus.ab_w, bus.alu_out_w, bus.mdr_w,
                     bus.epc_w, bus.ula_c, bus.m_mem, bus.m_writereg, bus.m_wdata, bus.m_ula_a,
                     bus.m_ula_b, bus.m_pc, bus.exc_cause};
            checks++;
            if (got_v !== exp_v)begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%h required=%h", cyc, got_v, exp_v);
            end
        end
        if (stim_done) begin
            drain++;
            if (sb.size() == 0 || drain > 10) begin
                if (sb.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain left=%0d required=0", sb.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    logic [5:0] op_tab [8];

    initial begin
        int   sel;
        int   cut;
        logic [5:0] op;
        logic [5:0] fn;
        logic ofv;
        logic eqv;
        op_tab = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        reset = 1'b1;
        bus.opcode = '0; bus.funct = '0; bus.of = 1'b0; bus.eq = 1'b0;
        @(posedge clk); #1;
        do_reset(2);

        do_instr(6'h00, 6'h22, 1'b0, 1'b0);
        do_instr(6'h00, 6'h20, 1'b1, 1'b0);
        do_instr(6'h00, 6'h24, 1'b0, 1'b1);
        do_instr(6'h00, 6'h3F, 1'b0, 1'b0);
        do_instr(6'h23, 6'h00, 1'b1, 1'b1);
        do_instr(6'h2B, 6'h00, 1'b1, 1'b0);
        do_instr(6'h04, 6'h00, 1'b0, 1'b1);
        do_instr(6'h04, 6'h00, 1'b0, 1'b0);
        do_instr(6'h05, 6'h00, 1'b0, 1'b1);
        do_instr(6'h05, 6'h00, 1'b0, 1'b0);
        do_instr(6'h08, 6'h00, 1'b1, 1'b0);
        do_instr(6'h08, 6'h00, 1'b0, 1'b0);
        do_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        do_instr(6'h02, 6'h00, 1'b0, 1'b0);
        do_instr(6'h08, 6'h00, 1'b1, 1'b0);

        // Interrupt a load in its memory-access cycle, then restart cleanly.
        plan_instr(6'h23, 6'h00, 1'b0, 1'b0);
        run_plan(6'h23, 6'h00, 1'b0, 1'b0, 6);
        do_reset(3);
        do_instr(6'h02, 6'h00, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 8);
            op  = (sel == 8) ? 6'($urandom) : op_tab[sel];
            sel = $urandom_range(0, 3);
            fn  = (sel == 0) ? 6'h20 : (sel == 1) ? 6'h22 : (sel == 2) ? 6'h24 : 6'($urandom);
            ofv = 1'($urandom);
            eqv = 1'($urandom);
            plan_instr(op, fn, ofv, eqv);
            cut = ($urandom_range(0, 15) == 0) ? $urandom_range(1, plan.size()) : plan.size();
            run_plan(op, fn, ofv, eqv, cut);
            if (cut < plan.size()) do_reset($urandom_range(1, 3));
        end
        stim_done = 1'b1;
    end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multicycle control unit for the MIPS-subset datapath. It decodes opcode/funct from the instruction register and ULA flags. Each cycle it drives every write enable, mux select and ULA operation the datapath consumes. It sits directly upstream of the datapath top and owns no data registers, only its state register.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- of  in  1  ULA overflow, combinational, current cycle
- eq  in  1  ULA equal flag, combinational, current cycle
- pc_w, mem_w, ir_w, rb_w, ab_w, alu_out_w, mdr_w, epc_w  out  1 each  write enables
- ula_c  out  3  ULA op: 000 pass A, 001 add, 010 sub, 011 and, 111 compare
- m_mem  out  2  memory address: 0 PC, 1 ALUOut
- m_writereg  out  2  dest reg: 0 rt, 1 rd, 3 const 29
- m_wdata  out  3  write data: 0 ALUOut, 1 MDR, 2 const 227
- m_ula_a  out  1  0 PC, 1 A
- m_ula_b  out  2  0 B, 1 const 4, 2 sext(imm), 3 sext(imm)<<2
- m_pc  out  2  0 ULA result, 1 ALUOut, 2 jump target, 3 exception vector
- exc_cause  out  1  0 invalid opcode, 1 overflow

## Operation
- Moore FSM. All outputs are decoded from the registered state. Exception: `pc_w` in BR also depends on `eq`. Unlisted outputs are 0 in every state.
- RST_SP: `rb_w`=1, `m_writereg`=3, `m_wdata`=2, which writes $sp=227. Next state is FETCH.
- FETCH: `m_mem`=0, `m_ula_a`=0, `m_ula_b`=1, `ula_c`=001, `pc_w`=1, `m_pc`=0. This updates PC<=PC+4. Next state MEM_WAIT.
- MEM_WAIT: idle, covering the 1-cycle memory read latency. Next state IR_LOAD.
- IR_LOAD: `ir_w`=1. Next state DECODE.
- DECODE: `ab_w`=1, `m_ula_a`=0, `m_ula_b`=3, `ula_c`=001, `alu_out_w`=1. This precomputes the branch target. Dispatch on `opcode`:
  - 0x00 → R_EXEC
  - 0x08 → I_EXEC
  - 0x23 / 0x2B → ADDR
  - 0x04 / 0x05 → BR
  - 0x02 → JMP
  - other → EXC_EPC with cause 0 (EXC_EN only)
- R_EXEC: `m_ula_a`=1, `m_ula_b`=0, `alu_out_w`=1. `ula_c` is 001 for funct 0x20, 010 for 0x22, 011 for 0x24.
  - Any other funct is treated as an invalid instruction: cause 0 under EXC_EN, else back to FETCH.
  - Next state R_WB.
- R_WB: `rb_w`=1, `m_writereg`=1, `m_wdata`=0. Next state FETCH.
- I_EXEC: `m_ula_a`=1, `m_ula_b`=2, `ula_c`=001, `alu_out_w`=1. Next state I_WB.
- I_WB: `rb_w`=1, `m_writereg`=0, `m_wdata`=0. Next state FETCH.
- ADDR: as I_EXEC. Next state LW_MEM for opcode 0x23, SW_MEM for 0x2B.
- SW_MEM: `m_mem`=1, `mem_w`=1. Next state FETCH.
- LW path: LW_MEM (`m_mem`=1) → LW_WAIT → LW_MDR (`mdr_w`=1) → LW_WB.
- LW_WB: `rb_w`=1, `m_writereg`=0, `m_wdata`=1. Next state FETCH.
- BR: `m_ula_a`=1, `m_ula_b`=0, `ula_c`=111, `m_pc`=1. `pc_w` = eq for opcode 0x04, = !eq for opcode 0x05. Next state FETCH.
- JMP: `pc_w`=1, `m_pc`=2. Next state FETCH.
- EXC_EPC: `m_ula_a`=0, `m_ula_b`=1, `ula_c`=010, `epc_w`=1. This stores EPC = PC−4. Next state EXC_VEC.
- EXC_VEC: `pc_w`=1, `m_pc`=3. Next state FETCH.
- `exc_cause` is a registered bit, set on entry to EXC_EPC and held until the next exception.

## Timing
- Reset:
  - `reset`=1 at a clock edge forces state=RST_SP and `exc_cause`=0 from any state, including mid-instruction. No partial writes are completed.
  - While reset is high, outputs are RST_SP values: `rb_w`=1, `m_writereg`=3, `m_wdata`=2, all others 0.
  - The first cycle after deassertion is still RST_SP; FETCH follows.
- Cycles per instruction, counted FETCH to the last state inclusive:
  - R / addi: 6
  - lw: 9
  - sw: 6
  - beq/bne: 5
  - j: 5
  - exception: 4 + 2 from DECODE, or 5 + 2 from an EXEC state.
- `of` and `eq` are sampled only in the states that compute them (R_EXEC, I_EXEC, BR) and are ignored elsewhere.

## Configuration
- `CTRL_EXC_EN` defined:
  - `of`=1 in R_EXEC or I_EXEC goes to EXC_EPC with cause 1; the write-back state is skipped, so no `rb_w`.
  - An unknown opcode or funct goes to EXC_EPC with cause 0.
- `CTRL_EXC_EN` undefined:
  - EXC states are not built; `epc_w` is tied 0 and `exc_cause` is tied 0.
  - Overflow is ignored and write-back happens.
  - An unknown opcode or funct returns to FETCH.

## Structure
- `ctrl_pkg` contains:
  - the state enum
  - opcode and funct constants
  - `ula_c` encodings
  - all mux select constants, shared with the datapath top.
- One sub-module, `ctrl_out_dec`: a combinational map from state to the output bundle. `pc_w` for BR is gated in the parent.

## Test plan
- Hold `reset` 3 cycles mid-lw, then release → `rb_w`=1, `m_writereg`=3, `m_wdata`=2 through the release cycle; next cycle FETCH with `pc_w`=1, `ula_c`=001.
- opcode 0x00, funct 0x22, `of`=0 → `ula_c`=010 in cycle 5; `rb_w`=1 with `m_writereg`=1 in cycle 6; FETCH in cycle 7.
- opcode 0x23 → `m_mem`=1 in cycle 6; `mdr_w`=1 in cycle 8; `rb_w`=1 with `m_wdata`=1 in cycle 9. Opcode 0x2B → `mem_w`=1 only in cycle 6.
- opcode 0x04 with `eq`=1 → `pc_w`=1, `m_pc`=1 in cycle 5. With `eq`=0 → `pc_w`=0. Opcode 0x05 gives the inverse result.
- `CTRL_EXC_EN`, opcode 0x08 with `of`=1 in cycle 5 → no `rb_w`; cycle 6 `epc_w`=1, `ula_c`=010; cycle 7 `pc_w`=1, `m_pc`=3, `exc_cause`=1. Without the macro → `rb_w`=1 in cycle 6.
- opcode 0x3F → with `CTRL_EXC_EN`, EXC_EPC in cycle 5 with `exc_cause`=0. Without it, FETCH in cycle 5 and no write enables asserted.
